// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter: round-robin arbiter and sequencer for a shared 4:1
// 8-bit mux. It grants one requester at a time and limits each burst to
// MAX_HOLD cycles while other requesters are waiting. The grant, the select
// and the registered output byte all change on the same clock edge.
// Optional feature: define ARB_LOCK_EN to add the lock port. When the owner
// holds its lock bit, it keeps the grant past MAX_HOLD.
module mux4_rr_arbiter #(
  parameter int MAX_HOLD = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic [7:0] d0,
  input  logic [7:0] d1,
  input  logic [7:0] d2,
  input  logic [7:0] d3,
  output logic [3:0] grant,
  output logic [1:0] sel,
  output logic [7:0] y,
  output logic       y_valid
`ifdef ARB_LOCK_EN
  ,
  input  logic [3:0] lock
`endif
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [3:0] HOLD_MAX = 4'(MAX_HOLD);

  state_t     state, state_n;
  logic [3:0] grant_n;
  logic [1:0] sel_n;
  logic [1:0] last, last_n;
  logic [3:0] hold_cnt, hold_n;
  logic [7:0] y_n;
  logic       y_valid_n;
  logic [1:0] win;
  logic       others;
  logic       owner_lock;

  // Find the first requester after 'last', wrapping from 3 back to 0.
  // The owner's index equals 'last', so the owner is searched last.
  always_comb begin
    logic [1:0] cand;
    logic       found;
    win   = 2'd0;
    found = 1'b0;
    cand  = 2'd0;
    for (int i = 0; i < 4; i++) begin
      cand = last + 2'(i) + 2'd1;
      if (!found && req[cand]) begin
        win   = cand;
        found = 1'b1;
      end
    end
  end

  // Check whether any requester other than the current owner is waiting,
  // and whether the owner is asking to extend its burst.
  always_comb begin
    others = |(req & ~(4'b0001 << sel));
`ifdef ARB_LOCK_EN
    owner_lock = lock[sel];
`else
    owner_lock = 1'b0;
`endif
  end

  // Decide the next state, owner, burst count and registered output.
  always_comb begin
    state_n = state;
    grant_n = grant;
    sel_n   = sel;
    last_n  = last;
    hold_n  = hold_cnt;
    case (state)
      IDLE: begin
        grant_n = 4'b0000;
        if (|req) begin
          state_n = GRANT;
          grant_n = 4'b0001 << win;
          sel_n   = win;
          last_n  = win;
          hold_n  = 4'd1;
        end
      end
      GRANT: begin
        if (!req[sel]) begin
          if (others) begin
            grant_n = 4'b0001 << win;
            sel_n   = win;
            last_n  = win;
            hold_n  = 4'd1;
          end else begin
            state_n = IDLE;
            grant_n = 4'b0000;
            hold_n  = 4'd0;
          end
        end else if (owner_lock) begin
          hold_n = (hold_cnt < HOLD_MAX) ? hold_cnt + 4'd1 : HOLD_MAX;
        end else if (hold_cnt < HOLD_MAX) begin
          hold_n = hold_cnt + 4'd1;
        end else if (others) begin
          grant_n = 4'b0001 << win;
          sel_n   = win;
          last_n  = win;
          hold_n  = 4'd1;
        end else begin
          hold_n = 4'd1;
        end
      end
      default: begin
        state_n = IDLE;
        grant_n = 4'b0000;
      end
    endcase

    y_valid_n = |grant_n;
    y_n       = y;
    if (y_valid_n) begin
      case (sel_n)
        2'd0:    y_n = d0;
        2'd1:    y_n = d1;
        2'd2:    y_n = d2;
        default: y_n = d3;
      endcase
    end
  end

  // Register the arbiter state and the output byte together. This keeps
  // grant, sel, y and y_valid aligned on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      grant    <= 4'b0000;
      sel      <= 2'd0;
      last     <= 2'd3;
      hold_cnt <= 4'd0;
      y        <= 8'h00;
      y_valid  <= 1'b0;
    end else begin
      state    <= state_n;
      grant    <= grant_n;
      sel      <= sel_n;
      last     <= last_n;
      hold_cnt <= hold_n;
      y        <= y_n;
      y_valid  <= y_valid_n;
    end
  end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed testbench for mux4_rr_arbiter with MAX_HOLD = 4.
// The expected outputs in every step are worked out by hand.
module tb_mux4_rr_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [7:0] d0, d1, d2, d3;
  logic [3:0] grant;
  logic [1:0] sel;
  logic [7:0] y;
  logic       y_valid;
`ifdef ARB_LOCK_EN
  logic [3:0] lock;
`endif

  int vectors;
  int miscompares;

  mux4_rr_arbiter #(.MAX_HOLD(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .d0      (d0),
    .d1      (d1),
    .d2      (d2),
    .d3      (d3),
    .grant   (grant),
    .sel     (sel),
    .y       (y),
    .y_valid (y_valid)
`ifdef ARB_LOCK_EN
    ,
    .lock    (lock)
`endif
  );

  // Free-running clock with a 10-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one rising edge, then wait 1 unit so outputs are read after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = 4'b0000;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = 4'b1111;
    for (int i = 0; i < 2; i++) begin
      step();
      vectors++;
      if ({grant, sel, y, y_valid} !== {4'b0000, 2'd0, 8'h00, 1'b0}) begin
        miscompares++;
        $display("[TB] FAIL reset_hold[%0d]: got grant=%b sel=%0d y=%h v=%b, want 0000/0/00/0",
                 i, grant, sel, y, y_valid);
      end
    end
    rst = 1'b0;
    step();
    vectors++;
    if ({grant, sel, y, y_valid} !== {4'b0001, 2'd0, 8'hA0, 1'b1}) begin
      miscompares++;
      $display("[TB] FAIL reset_release: got grant=%b sel=%0d y=%h v=%b, want 0001/0/a0/1",
               grant, sel, y, y_valid);
    end
  endtask

  task automatic test_single();
    do_reset();
    req = 4'b0100;
    for (int i = 0; i < 10; i++) begin
      step();
      vectors++;
      if ({grant, sel, y, y_valid} !== {4'b0100, 2'd2, 8'hA2, 1'b1}) begin
        miscompares++;
        $display("[TB] FAIL single[%0d]: got grant=%b sel=%0d y=%h v=%b, want 0100/2/a2/1",
                 i, grant, sel, y, y_valid);
      end
    end
    req = 4'b0000;
    step();
    vectors++;
    if ({grant, sel, y, y_valid} !== {4'b0000, 2'd2, 8'hA2, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL single_release: got grant=%b sel=%0d y=%h v=%b, want 0000/2/a2/0",
               grant, sel, y, y_valid);
    end
    // Last owner was 2, so the next search starts at 3 and wraps to 0.
    req = 4'b0101;
    step();
    vectors++;
    if ({grant, sel, y, y_valid} !== {4'b0001, 2'd0, 8'hA0, 1'b1}) begin
      miscompares++;
      $display("[TB] FAIL idle_wrap: got grant=%b sel=%0d y=%h v=%b, want 0001/0/a0/1",
               grant, sel, y, y_valid);
    end
  endtask

  task automatic test_contention();
    logic [3:0] eg;
    logic [1:0] es;
    do_reset();
    req = 4'b1111;
    for (int i = 0; i < 20; i++) begin
      step();
      es = 2'((i / 4) % 4);
      eg = 4'b0001 << es;
      vectors++;
      if ({grant, sel, y, y_valid} !== {eg, es, 8'hA0 + 8'(es), 1'b1}) begin
        miscompares++;
        $display("[TB] FAIL contention[%0d]: got grant=%b sel=%0d y=%h v=%b, want %b/%0d/%h/1",
                 i, grant, sel, y, y_valid, eg, es, 8'hA0 + 8'(es));
      end
    end
  endtask

  task automatic test_early_release();
    do_reset();
    req = 4'b1001;
    for (int i = 0; i < 2; i++) begin
      step();
      vectors++;
      if ({grant, sel, y, y_valid} !== {4'b0001, 2'd0, 8'hA0, 1'b1}) begin
        miscompares++;
        $display("[TB] FAIL early_owner[%0d]: got grant=%b sel=%0d y=%h v=%b, want 0001/0/a0/1",
                 i, grant, sel, y, y_valid);
      end
    end
    req = 4'b1000;
    step();
    vectors++;
    if ({grant, sel, y, y_valid} !== {4'b1000, 2'd3, 8'hA3, 1'b1}) begin
      miscompares++;
      $display("[TB] FAIL early_handoff: got grant=%b sel=%0d y=%h v=%b, want 1000/3/a3/1",
               grant, sel, y, y_valid);
    end
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    req = 4'b0100;
    step();
    step();
    vectors++;
    if ({grant, sel, y_valid} !== {4'b0100, 2'd2, 1'b1}) begin
      miscompares++;
      $display("[TB] FAIL mid_setup: got grant=%b sel=%0d v=%b, want 0100/2/1",
               grant, sel, y_valid);
    end
    rst = 1'b1;
    step();
    vectors++;
    if ({grant, sel, y, y_valid} !== {4'b0000, 2'd0, 8'h00, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL mid_reset: got grant=%b sel=%0d y=%h v=%b, want 0000/0/00/0",
               grant, sel, y, y_valid);
    end
    rst = 1'b0;
    req = 4'b1111;
    step();
    vectors++;
    if ({grant, sel, y, y_valid} !== {4'b0001, 2'd0, 8'hA0, 1'b1}) begin
      miscompares++;
      $display("[TB] FAIL mid_restart: got grant=%b sel=%0d y=%h v=%b, want 0001/0/a0/1",
               grant, sel, y, y_valid);
    end
  endtask

`ifdef ARB_LOCK_EN
  task automatic test_lock();
    do_reset();
    lock = 4'b0001;
    req  = 4'b0011;
    for (int i = 0; i < 8; i++) begin
      step();
      vectors++;
      if ({grant, sel, y_valid} !== {4'b0001, 2'd0, 1'b1}) begin
        miscompares++;
        $display("[TB] FAIL lock_hold[%0d]: got grant=%b sel=%0d v=%b, want 0001/0/1",
                 i, grant, sel, y_valid);
      end
    end
    lock = 4'b0000;
    step();
    vectors++;
    if ({grant, sel, y, y_valid} !== {4'b0010, 2'd1, 8'hA1, 1'b1}) begin
      miscompares++;
      $display("[TB] FAIL lock_release: got grant=%b sel=%0d y=%h v=%b, want 0010/1/a1/1",
               grant, sel, y, y_valid);
    end
  endtask
`endif

  // Run each scenario in order, then print the summary line.
  initial begin
    vectors     = 0;
    miscompares = 0;
    rst = 1'b1;
    req = 4'b0000;
    d0  = 8'hA0;
    d1  = 8'hA1;
    d2  = 8'hA2;
    d3  = 8'hA3;
`ifdef ARB_LOCK_EN
    lock = 4'b0000;
`endif
    #1;
    test_reset();
    test_single();
    test_contention();
    test_early_release();
    test_reset_mid_burst();
`ifdef ARB_LOCK_EN
    test_lock();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
